mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Multi-cycle MIPS32 integer core; successor to the single-cycle CPU. One FSM-sequenced datapath
//  shares a single memory port with a req/ready handshake, so fetch and data memories may be slow.
//  Adds a programmable reset vector, a memory wait timeout, and a trap/halt state.
//  Sits between the SoC memory arbiter and the debug/trace logic.
// PARAMETERS
//  RESET_PC     32'h00400020  PC loaded on reset
//  WAIT_LIMIT   16            max stall cycles per memory access before timeout trap; 0 = no limit
//  TRAP_MISALGN 1             1: lw/sw with addr[1:0]!=0 traps; 0: addr[1:0] forced to 00
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous reset, active-high
//  mem_req    out  1   memory request valid
//  mem_we     out  1   1 = write (sw), 0 = read
//  mem_addr   out  32  byte address, word aligned
//  mem_wdata  out  32  store data (rt)
//  mem_rdata  in   32  read data, valid in the cycle mem_ready=1
//  mem_ready  in   1   completes the pending request this cycle
//  retire     out  1   1-cycle pulse when an instruction commits
//  pc_out     out  32  PC of the instruction in flight
//  halted     out  1   core in TRAP state
//  trap_cause out  2   0 none, 1 illegal opcode/funct, 2 misaligned, 3 memory timeout
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=IDLE, pc=RESET_PC, mem_req=0, retire=0, halted=0,
//   trap_cause=0, regs r1..r31 = 0. Reset overrides everything; an open request is abandoned.
//  States: IDLE -> FETCH -> DECODE -> {EXEC | FETCH(j)} -> {MEM | WB | FETCH(beq)} -> ...; TRAP is terminal.
//  IDLE : one cycle, then FETCH.
//  FETCH: mem_req=1, we=0, addr=pc. On mem_ready, latch IR=mem_rdata -> DECODE.
//  DECODE: A=rs, B=rt, target = pc+4 + (sext(imm16)<<2).
//   j: pc <= {pc4[31:28], imm26, 2'b00}, retire -> FETCH.
//   Unsupported opcode -> TRAP, cause 1.
//  EXEC: ALU. R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; other funct -> TRAP cause 1.
//   addi/lw/sw: A + sext(imm16). beq: pc <= (A==B) ? target : pc+4, retire -> FETCH.
//   R/addi -> WB. lw/sw -> misalign check (TRAP cause 2), else MEM.
//  MEM: mem_req=1, addr=ALUout, we=(sw), wdata=B. On mem_ready: lw latches MDR -> WB;
//   sw: pc+=4, retire -> FETCH.
//  WB: rd (R-type) or rt (addi/lw) <= ALUout/MDR; pc+=4; retire -> FETCH.
//  Arithmetic: 32-bit wrap, no overflow exception. slt is signed. Writes to r0 are discarded;
//   r0 always reads 0.
//  Handshake: while mem_req=1, addr/we/wdata are held stable until the mem_ready cycle.
//   mem_ready while mem_req=0 is ignored. mem_req drops in the cycle after completion unless
//   the next state also requests.
//  Timeout: a counter clears on entry to FETCH/MEM and increments on each cycle with
//   mem_req=1 and mem_ready=0. When it reaches WAIT_LIMIT (WAIT_LIMIT!=0): -> TRAP, cause 3, mem_req=0.
//  TRAP: halted=1, mem_req=0, pc_out frozen at the faulting instruction, no register or
//   memory writes; only reset exits.
//  Latency with mem_ready tied 1: j 3, beq 4, R/addi/sw 5, lw 6 cycles, counted from the
//   FETCH request to the retire pulse.
// TESTING
//  Reset with mem_ready=1 -> first mem_req in the 2nd cycle after reset falls, mem_addr=0x00400020.
//  addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x10(r0) -> write request addr 0x10, wdata 12;
//   then lw r4,0x10(r0) returning 12 -> r4=12; 4 retire pulses for the first 4 instructions.
//  beq r1,r1,+2 at 0x00400020 -> next fetch at 0x0040002C. Same branch with r1!=r2 -> 0x00400024.
//   j 0x0100000 -> next fetch at 0x00400000.
//  mem_ready held low 3 cycles on fetch -> mem_addr stable; no retire until ready. Held low 16
//   cycles (WAIT_LIMIT=16) -> halted=1, trap_cause=3.
//  lw at addr 0x11 -> halted=1, cause 2, no MEM request issued; opcode 0x3F -> cause 1.
//   Reset asserted mid-MEM stall -> mem_req=0 next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 integer core: one FSM-sequenced datapath sharing a single req/ready memory port,
// with a programmable reset vector, a memory wait timeout and a terminal trap state.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC     = 32'h00400020,
    parameter int          WAIT_LIMIT   = 16,
    parameter bit          TRAP_MISALGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [5:0]  OP_R    = 6'h00;
    localparam logic [5:0]  OP_J    = 6'h02;
    localparam logic [5:0]  OP_BEQ  = 6'h04;
    localparam logic [5:0]  OP_ADDI = 6'h08;
    localparam logic [5:0]  OP_LW   = 6'h23;
    localparam logic [5:0]  OP_SW   = 6'h2B;
    localparam logic [31:0] WAIT_LIM_W = 32'(WAIT_LIMIT);
    localparam bit          HAS_LIMIT  = (WAIT_LIMIT != 0);

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_target;
    logic [31:0] r_mem_addr, r_mem_wdata, r_wait;
    logic        r_mem_req, r_mem_we, r_retire, r_halted;
    logic [1:0]  r_cause;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_dest;
    logic [31:0] w_imm_sext, w_pc4, w_ea, w_br_pc, w_j_pc, w_wb_data, w_wait_nxt, w_alu;
    logic        w_timeout, w_bad_funct;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_pc4      = r_pc + 32'd4;
    assign w_ea       = r_a + w_imm_sext;
    assign w_br_pc    = (r_a == r_b) ? r_target : w_pc4;
    assign w_j_pc     = {w_pc4[31:28], r_ir[25:0], 2'b00};
    assign w_dest     = (w_op == OP_R) ? w_rd : w_rt;
    assign w_wb_data  = (w_op == OP_LW) ? r_mdr : r_alu;
    assign w_wait_nxt = r_wait + 32'd1;
    assign w_timeout  = HAS_LIMIT && (w_wait_nxt == WAIT_LIM_W);

    always_comb begin
        w_alu       = '0;
        w_bad_funct = 1'b0;
        case (w_funct)
            6'h20:   w_alu = r_a + r_b;
            6'h22:   w_alu = r_a - r_b;
            6'h24:   w_alu = r_a & r_b;
            6'h25:   w_alu = r_a | r_b;
            6'h2A:   w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
            default: w_bad_funct = 1'b1;
        endcase
    end

    // Every path back to FETCH loads pc and the fetch request together so the bus never sees a stale address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_retire  <= 1'b0;
            r_halted  <= 1'b0;
            r_cause   <= 2'd0;
            r_wait    <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH; r_mem_req <= 1'b1; r_mem_we <= 1'b0;
                    r_mem_addr <= r_pc; r_wait <= '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata; r_mem_req <= 1'b0; r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP; r_halted <= 1'b1; r_cause <= 2'd3; r_mem_req <= 1'b0;
                    end else begin
                        r_wait <= w_wait_nxt;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_target <= w_pc4 + {w_imm_sext[29:0], 2'b00};
                    case (w_op)
                        OP_J: begin
                            r_pc <= w_j_pc; r_retire <= 1'b1; r_state <= S_FETCH;
                            r_mem_req <= 1'b1; r_mem_we <= 1'b0; r_mem_addr <= w_j_pc; r_wait <= '0;
                        end
                        OP_R, OP_BEQ, OP_ADDI, OP_LW, OP_SW: r_state <= S_EXEC;
                        default: begin
                            r_state <= S_TRAP; r_halted <= 1'b1; r_cause <= 2'd1;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (w_op)
                        OP_R: begin
                            if (w_bad_funct) begin
                                r_state <= S_TRAP; r_halted <= 1'b1; r_cause <= 2'd1;
                            end else begin
                                r_alu <= w_alu; r_state <= S_WB;
                            end
                        end
                        OP_ADDI: begin
                            r_alu <= w_ea; r_state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            if (TRAP_MISALGN && (w_ea[1:0] != 2'b00)) begin
                                r_state <= S_TRAP; r_halted <= 1'b1; r_cause <= 2'd2;
                            end else begin
                                r_alu <= w_ea; r_state <= S_MEM; r_mem_req <= 1'b1;
                                r_mem_we <= (w_op == OP_SW); r_mem_addr <= {w_ea[31:2], 2'b00};
                                r_mem_wdata <= r_b; r_wait <= '0;
                            end
                        end
                        OP_BEQ: begin
                            r_pc <= w_br_pc; r_retire <= 1'b1; r_state <= S_FETCH;
                            r_mem_req <= 1'b1; r_mem_we <= 1'b0; r_mem_addr <= w_br_pc; r_wait <= '0;
                        end
                        default: begin
                            r_state <= S_TRAP; r_halted <= 1'b1; r_cause <= 2'd1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (r_mem_we) begin
                            r_pc <= w_pc4; r_retire <= 1'b1; r_state <= S_FETCH;
                            r_mem_req <= 1'b1; r_mem_we <= 1'b0; r_mem_addr <= w_pc4; r_wait <= '0;
                        end else begin
                            r_mdr <= mem_rdata; r_mem_req <= 1'b0; r_state <= S_WB;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_TRAP; r_halted <= 1'b1; r_cause <= 2'd3;
                        r_mem_req <= 1'b0; r_mem_we <= 1'b0;
                    end else begin
                        r_wait <= w_wait_nxt;
                    end
                end
                S_WB: begin
                    if (w_dest != 5'd0) r_regs[w_dest] <= w_wb_data;
                    r_pc <= w_pc4; r_retire <= 1'b1; r_state <= S_FETCH;
                    r_mem_req <= 1'b1; r_mem_we <= 1'b0; r_mem_addr <= w_pc4; r_wait <= '0;
                end
                default: begin
                    r_mem_req <= 1'b0; r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign retire     = r_retire;
    assign pc_out     = r_pc;
    assign halted     = r_halted;
    assign trap_cause = r_cause;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small word memory with a bench-controlled ready line.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset, mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [1:0]  trap_cause;
    logic        tb_ready;
    logic [31:0] mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign mem_ready = tb_ready;
    assign mem_rdata = mem[mem_addr[9:2]];

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire),
        .pc_out(pc_out), .halted(halted), .trap_cause(trap_cause)
    );

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    // Leaves the bench at the negedge where reset drops; the next negedge is the first FETCH cycle.
    task automatic do_reset(input logic rdy);
        @(negedge clk); reset = 1'b1; tb_ready = rdy;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem(); mem[8] = 32'h20010005;
        @(negedge clk); reset = 1'b1; tb_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL reset_retire: got %b want 0", retire); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (trap_cause !== 2'd0) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", trap_cause); end
        n_cmp++; if (pc_out !== 32'h00400020) begin n_bad++; $display("FAIL reset_pc: got %h want 00400020", pc_out); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL first_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h00400020) begin n_bad++; $display("FAIL first_addr: got %h want 00400020", mem_addr); end
    endtask

    task automatic test_program();
        logic [31:0] exp_wa [7] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h08, 32'h04, 32'h0C};
        logic [31:0] exp_wd [7] = '{32'd12, 32'd12, 32'hFFFFFFFE, 32'd1, 32'd5, 32'd7, 32'd0};
        int          exp_rc [6] = '{5, 9, 13, 17, 22, 26};
        logic [31:0] wa [8];
        logic [31:0] wd [8];
        int          rc [6];
        int          nret = 0, nwr = 0;
        logic        saw_lw = 1'b0, done = 1'b0;
        clear_mem();
        mem[8]  = 32'h20010005; mem[9]  = 32'h20020007; mem[10] = 32'h00221820; mem[11] = 32'hAC030010;
        mem[12] = 32'h8C040010; mem[13] = 32'hAC040014; mem[14] = 32'h00222822; mem[15] = 32'h00A1302A;
        mem[16] = 32'hAC050018; mem[17] = 32'hAC06001C; mem[18] = 32'h00223824; mem[19] = 32'h00224025;
        mem[20] = 32'hAC070008; mem[21] = 32'hAC080004; mem[22] = 32'h20000009; mem[23] = 32'hAC00000C;
        mem[4]  = 32'd12;
        for (int k = 0; k < 8; k++) begin wa[k] = '0; wd[k] = '0; end
        for (int k = 0; k < 6; k++) rc[k] = 0;
        do_reset(1'b1);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (retire === 1'b1) begin if (nret < 6) rc[nret] = i; nret++; end
            if (mem_req && mem_we && mem_ready) begin
                if (nwr < 8) begin wa[nwr] = mem_addr; wd[nwr] = mem_wdata; end
                nwr++;
            end
            if (mem_req && !mem_we && mem_addr == 32'h10) saw_lw = 1'b1;
            if (halted === 1'b1) begin done = 1'b1; break; end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL prog_end: halted never seen, got %b want 1", done); end
        n_cmp++; if (trap_cause !== 2'd1) begin n_bad++; $display("FAIL prog_cause: got %0d want 1", trap_cause); end
        n_cmp++; if (pc_out !== 32'h00400060) begin n_bad++; $display("FAIL prog_trap_pc: got %h want 00400060", pc_out); end
        n_cmp++; if (nret !== 16) begin n_bad++; $display("FAIL prog_retires: got %0d want 16", nret); end
        n_cmp++; if (nwr !== 7) begin n_bad++; $display("FAIL prog_writes: got %0d want 7", nwr); end
        n_cmp++; if (saw_lw !== 1'b1) begin n_bad++; $display("FAIL prog_lw_read: got %b want 1", saw_lw); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (rc[k] !== exp_rc[k]) begin n_bad++; $display("FAIL retire_cycle%0d: got %0d want %0d", k, rc[k], exp_rc[k]); end
        end
        for (int k = 0; k < 7; k++) begin
            n_cmp++; if (wa[k] !== exp_wa[k]) begin n_bad++; $display("FAIL wr_addr%0d: got %h want %h", k, wa[k], exp_wa[k]); end
            n_cmp++; if (wd[k] !== exp_wd[k]) begin n_bad++; $display("FAIL wr_data%0d: got %h want %h", k, wd[k], exp_wd[k]); end
        end
    endtask

    task automatic test_branch();
        clear_mem(); mem[8] = 32'h10210002;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL beq_taken_retire: got %b want 1", retire); end
        n_cmp++; if (mem_addr !== 32'h0040002C) begin n_bad++; $display("FAIL beq_taken_addr: got %h want 0040002c", mem_addr); end
        clear_mem(); mem[8] = 32'h20010001; mem[9] = 32'h10220002;
        do_reset(1'b1);
        repeat (8) @(negedge clk);
        n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL beq_fall_retire: got %b want 1", retire); end
        n_cmp++; if (mem_addr !== 32'h00400028) begin n_bad++; $display("FAIL beq_fall_addr: got %h want 00400028", mem_addr); end
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL beq_fall_req: got %b want 1", mem_req); end
    endtask

    task automatic test_jump();
        clear_mem(); mem[8] = 32'h08100000;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL j_early_retire: got %b want 0", retire); end
        @(negedge clk);
        n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL j_retire: got %b want 1", retire); end
        n_cmp++; if (mem_addr !== 32'h00400000) begin n_bad++; $display("FAIL j_addr: got %h want 00400000", mem_addr); end
    endtask

    task automatic test_stall();
        clear_mem(); mem[8] = 32'h20010005;
        do_reset(1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                n_cmp++; if (mem_addr !== 32'h00400020 || mem_req !== 1'b1) begin
                    n_bad++; $display("FAIL stall_hold%0d: got req=%b addr=%h want req=1 addr=00400020", i, mem_req, mem_addr);
                end
            end
            n_cmp++; if (retire !== (i == 8)) begin n_bad++; $display("FAIL stall_retire%0d: got %b want %b", i, retire, (i == 8)); end
            tb_ready = (i >= 4);
        end
    endtask

    task automatic test_timeout();
        clear_mem(); mem[8] = 32'h20010005;
        do_reset(1'b0);
        repeat (16) @(negedge clk);
        n_cmp++; if (halted !== 1'b0 || mem_req !== 1'b1) begin
            n_bad++; $display("FAIL tmo_early: got halted=%b req=%b want halted=0 req=1", halted, mem_req);
        end
        @(negedge clk);
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL tmo_halted: got %b want 1", halted); end
        n_cmp++; if (trap_cause !== 2'd3) begin n_bad++; $display("FAIL tmo_cause: got %0d want 3", trap_cause); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL tmo_req: got %b want 0", mem_req); end
        n_cmp++; if (pc_out !== 32'h00400020) begin n_bad++; $display("FAIL tmo_pc: got %h want 00400020", pc_out); end
        tb_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (halted !== 1'b1 || mem_req !== 1'b0 || retire !== 1'b0) begin
            n_bad++; $display("FAIL tmo_sticky: got halted=%b req=%b retire=%b want 1 0 0", halted, mem_req, retire);
        end
    endtask

    task automatic test_misalign();
        clear_mem(); mem[8] = 32'h8C010011;
        do_reset(1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL misalign_req%0d: got %b want 0", i, mem_req); end
            end
            if (i == 4) begin
                n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL misalign_halted: got %b want 1", halted); end
                n_cmp++; if (trap_cause !== 2'd2) begin n_bad++; $display("FAIL misalign_cause: got %0d want 2", trap_cause); end
                n_cmp++; if (pc_out !== 32'h00400020) begin n_bad++; $display("FAIL misalign_pc: got %h want 00400020", pc_out); end
            end
        end
    endtask

    task automatic test_illegal();
        clear_mem(); mem[8] = 32'hFC000000;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL illegal_halted: got %b want 1", halted); end
        n_cmp++; if (trap_cause !== 2'd1) begin n_bad++; $display("FAIL illegal_cause: got %0d want 1", trap_cause); end
        n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL illegal_retire: got %b want 0", retire); end
    endtask

    task automatic test_reset_mid_mem();
        clear_mem(); mem[8] = 32'h8C010010;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        tb_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            n_bad++; $display("FAIL mid_mem_req: got req=%b we=%b addr=%h want 1 0 00000010", mem_req, mem_we, mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL mid_mem_reset_req: got %b want 0", mem_req); end
        n_cmp++; if (pc_out !== 32'h00400020) begin n_bad++; $display("FAIL mid_mem_reset_pc: got %h want 00400020", pc_out); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL mid_mem_reset_halted: got %b want 0", halted); end
        reset = 1'b0; tb_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tb_ready = 1'b1;
        clear_mem();
        test_reset();
        test_program();
        test_branch();
        test_jump();
        test_stall();
        test_timeout();
        test_misalign();
        test_illegal();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
